uart_autobaud: RTL and testbench
================================

Name: uart_autobaud

Overview:
Auto-baud controller that configures the UART 16x oversampling tick generator at run time. On request it measures a 0x55 ('U') sync character on the synchronized RX line and derives the tick divisor. It validates the sync character's timing and publishes the divisor with a valid strobe and a lock flag. It sits between the RX pin synchronizer and the programmable baud tick generator; the divisor output feeds the generator's terminal-count compare.

Parameters:
CNT_W, 20, width of the measurement counter. Max measurable span is 2^CNT_W-1 cycles, which covers 9600 baud at 100 MHz.
DVSR_W, CNT_W-7, width of the divisor output.
DEFAULT_DVSR, 53, reset value of dvsr (115200 baud, 16x, 100 MHz clock).
IDLE_CYCLES, 16, consecutive high samples of rx required before arming.

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock, reset is asynchronous and active-high
rx  in  1  RX line, already synchronized to clk, idle high
start  in  1  one-cycle pulse that begins a detection; ignored while busy
abort  in  1  cancels a detection in progress
dvsr  out  DVSR_W  divisor for the tick generator (tick period = dvsr+1 clocks)
dvsr_valid  out  1  one-cycle pulse when dvsr is updated
locked  out  1  high once a detection has succeeded
busy  out  1  high in any state other than IDLE
error  out  1  one-cycle pulse when a detection fails

Behaviour:
- Reset values: dvsr=DEFAULT_DVSR, dvsr_valid=0, locked=0, busy=0, error=0, state=IDLE, rx_q=1.
- Falling-edge detect: fall = rx_q & ~rx, where rx_q is rx registered once. All edges share this one-cycle detect delay, so spans are exact.
- Sync char 0x55 (LSB first, 8N1) produces falling edges at bit times 0, 2, 4, 6, 8. The span from edge 1 to edge 5 is therefore 8 bit times.
- IDLE: on start go to WAIT_IDLE, clear the idle counter.
- WAIT_IDLE: count consecutive cycles with rx=1. Reset the count when rx=0. Go to WAIT_START when the count reaches IDLE_CYCLES.
- WAIT_START: wait indefinitely for fall. On fall go to MEASURE, clear the span counter C and the interval counter I, and set the edge count to 1.
- MEASURE: C and I increment every cycle. On each fall:
  - On the 2nd edge, store the reference interval R=I.
  - On the 3rd–5th edges, require R-(R>>2) <= I <= R+(R>>2). Otherwise fail.
  - In all cases, clear I and increment the edge count.
  - On the 5th edge, go to CALC.
- CALC (1 cycle): compute n=(C+64)>>7 using a CNT_W-bit add, i.e. round C/128. If n<2 or n>2^DVSR_W, fail. Otherwise dvsr<=n-1, dvsr_valid pulses, locked<=1, and go to IDLE.
- Latency: if edge 5 is detected in cycle k, CALC is cycle k+1 and dvsr/dvsr_valid are visible in cycle k+2.
- Fail: if C reaches 2^CNT_W-1 (saturates, no wrap), or an interval check fails, or CALC fails, then error pulses for 1 cycle and the state returns to IDLE. dvsr and locked are unchanged.
- abort in any non-IDLE state: go to IDLE next cycle. No error, dvsr/locked unchanged. abort has priority over fall in the same cycle.
- start and abort in IDLE in the same cycle: abort wins, stay IDLE.
- start while busy: ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).
- busy is registered from state. dvsr holds its value between updates; the tick generator may use it at any time.

Test Plan:
- 0x55 at 868 clocks/bit after start (C=6944) -> dvsr=53, dvsr_valid 1 cycle, locked=1, error=0, busy drops. dvsr_valid appears 2 cycles after the edge-5 detect cycle.
- 0x55 at 10417 clocks/bit (C=83336) -> dvsr=650, locked=1.
- 0x55 at 868 clocks/bit with the d2 high bit stretched so the 3rd interval is 2400 cycles (R=1736, limit 2170) -> error pulse at the 3rd-edge detect, dvsr stays 53, locked stays 0.
- 0x55 at 16 clocks/bit (C=128, n=1) -> error at CALC, dvsr unchanged.
- 0x55 at 140000 clocks/bit -> C saturates before edge 5 -> error, no wrap, state IDLE.
- After a lock, start then abort during MEASURE -> IDLE next cycle, no error, dvsr and locked=1 retained. Asserting reset then returns dvsr=53 and locked=0. rx held low at start keeps the block in WAIT_IDLE until 16 high cycles are seen.

Source files
------------

// File: rtl/uart_autobaud.sv
`timescale 1ns/1ps
// Auto-baud controller: times a 0x55 sync character on the synchronized RX line
// and publishes the 16x oversampling tick divisor for the baud generator.
module uart_autobaud #(
    parameter int CNT_W        = 20,
    parameter int DVSR_W       = CNT_W - 7,
    parameter int DEFAULT_DVSR = 53,
    parameter int IDLE_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    input  logic              abort,
    output logic [DVSR_W-1:0] dvsr,
    output logic              dvsr_valid,
    output logic              locked,
    output logic              busy,
    output logic              error
);

    localparam int                IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_MAX  = '1;
    localparam logic [CNT_W-1:0]  N_MAX  = CNT_W'(1) << DVSR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CALC
    } state_t;

    state_t              state_reg, state_next;
    logic                rx_q_reg;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [CNT_W-1:0]    c_reg, c_next;
    logic [CNT_W-1:0]    i_reg, i_next;
    logic [CNT_W-1:0]    r_reg, r_next;
    logic [2:0]          edge_cnt_reg, edge_cnt_next;
    logic [DVSR_W-1:0]   dvsr_reg, dvsr_next;
    logic                locked_reg, locked_next;
    logic                valid_reg, valid_next;
    logic                error_reg, error_next;
    logic                busy_reg, busy_next;

    logic                fall;
    logic [CNT_W-1:0]    i_cur;
    logic [CNT_W-1:0]    r_quarter;
    logic [CNT_W-1:0]    i_lo;
    logic [CNT_W:0]      i_hi;
    logic                in_range;
    logic [CNT_W-1:0]    n_val;
    logic                calc_ok;

    // Every edge sees the same one-cycle detect delay, so measured spans are exact.
    assign fall      = rx_q_reg & ~rx;
    // i_cur counts the cycles since the previous edge, including the current one.
    assign i_cur     = i_reg + 1'b1;
    assign r_quarter = r_reg >> 2;
    assign i_lo      = r_reg - r_quarter;
    assign i_hi      = {1'b0, r_reg} + {1'b0, r_quarter};
    assign in_range  = (i_cur >= i_lo) && ({1'b0, i_cur} <= i_hi);
    // Eight bit times of 16 ticks each: round C/128 to get ticks per period.
    assign n_val     = CNT_W'((c_reg + CNT_W'(64)) >> 7);
    assign calc_ok   = (n_val >= CNT_W'(2)) && (n_val <= N_MAX);

    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        c_next        = c_reg;
        i_next        = i_reg;
        r_next        = r_reg;
        edge_cnt_next = edge_cnt_reg;
        dvsr_next     = dvsr_reg;
        locked_next   = locked_reg;
        valid_next    = 1'b0;
        error_next    = 1'b0;

        if (state_reg != S_IDLE && abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_next    = S_WAIT_IDLE;
                        idle_cnt_next = '0;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!rx) begin
                        idle_cnt_next = '0;
                    end else if (idle_cnt_reg == IDLE_W'(IDLE_CYCLES - 1)) begin
                        state_next = S_WAIT_START;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
                S_WAIT_START: begin
                    if (fall) begin
                        state_next    = S_MEASURE;
                        c_next        = '0;
                        i_next        = '0;
                        edge_cnt_next = 3'd1;
                    end
                end
                S_MEASURE: begin
                    c_next = (c_reg == C_MAX) ? c_reg : c_reg + 1'b1;
                    i_next = i_cur;
                    if (c_reg == C_MAX) begin
                        error_next = 1'b1;
                        state_next = S_IDLE;
                    end else if (fall) begin
                        i_next        = '0;
                        edge_cnt_next = edge_cnt_reg + 1'b1;
                        if (edge_cnt_reg == 3'd1) begin
                            r_next = i_cur;
                        end
                        if (edge_cnt_reg != 3'd1 && !in_range) begin
                            error_next = 1'b1;
                            state_next = S_IDLE;
                        end else if (edge_cnt_reg == 3'd4) begin
                            state_next = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    state_next = S_IDLE;
                    if (calc_ok) begin
                        dvsr_next   = DVSR_W'(n_val - 1'b1);
                        valid_next  = 1'b1;
                        locked_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            rx_q_reg     <= 1'b1;
            idle_cnt_reg <= '0;
            c_reg        <= '0;
            i_reg        <= '0;
            r_reg        <= '0;
            edge_cnt_reg <= '0;
            dvsr_reg     <= DVSR_W'(DEFAULT_DVSR);
            locked_reg   <= 1'b0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rx_q_reg     <= rx;
            idle_cnt_reg <= idle_cnt_next;
            c_reg        <= c_next;
            i_reg        <= i_next;
            r_reg        <= r_next;
            edge_cnt_reg <= edge_cnt_next;
            dvsr_reg     <= dvsr_next;
            locked_reg   <= locked_next;
            valid_reg    <= valid_next;
            error_reg    <= error_next;
            busy_reg     <= busy_next;
        end
    end

    assign dvsr       = dvsr_reg;
    assign dvsr_valid = valid_reg;
    assign locked     = locked_reg;
    assign busy       = busy_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_uart_autobaud.sv
`timescale 1ns/1ps
// Bench for uart_autobaud: table of sync-character timings plus hand-written
// abort, idle-arming and reset sequences; result pulses are checked against a queue.
module tb_uart_autobaud;

    // A 14-bit counter keeps the saturation case short; scaling is otherwise identical.
    localparam int CNT_W  = 14;
    localparam int DVSR_W = CNT_W - 7;
    localparam int C_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx;
    logic              start;
    logic              abort;
    logic [DVSR_W-1:0] dvsr;
    logic              dvsr_valid;
    logic              locked;
    logic              busy;
    logic              error;

    uart_autobaud #(
        .CNT_W       (CNT_W),
        .DVSR_W      (DVSR_W),
        .DEFAULT_DVSR(53),
        .IDLE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .start     (start),
        .abort     (abort),
        .dvsr      (dvsr),
        .dvsr_valid(dvsr_valid),
        .locked    (locked),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    typedef struct {
        bit is_err;
        int dvsr;
        bit locked;
        int ref_cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Every dvsr_valid / error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (dvsr_valid || error)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", int'({dvsr_valid, error}), 0);
            end else begin
                mon_e = sb.pop_front();
                check("event_error",   int'(error),      int'(mon_e.is_err));
                check("event_valid",   int'(dvsr_valid), int'(!mon_e.is_err));
                check("event_latency", cyc - mon_e.ref_cyc, mon_e.lat);
                check("event_dvsr",    int'(dvsr),       mon_e.dvsr);
                check("event_locked",  int'(locked),     int'(mon_e.locked));
                check("event_busy",    int'(busy),       0);
                $display("event: %s dvsr=%0d locked=%0d latency=%0d",
                         error ? "error" : "valid", dvsr, locked, cyc - mon_e.ref_cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // 0x55 framed 8N1, LSB first; d2 (bit index 3) may be stretched.
    // The expectation is queued when the reference falling edge is driven.
    task automatic send_frame(input int bt, input int d2, input int ref_edge,
                              input bit is_err, input int e_dvsr, input bit e_locked,
                              input int lat);
        exp_t e;
        for (int b = 0; b < 10; b++) begin
            rx = (b % 2 == 1);
            if (b % 2 == 0 && (b / 2 + 1) == ref_edge) begin
                e.is_err  = is_err;
                e.dvsr    = e_dvsr;
                e.locked  = e_locked;
                e.ref_cyc = cyc;
                e.lat     = lat;
                sb.push_back(e);
            end
            tick(b == 3 ? d2 : (b == 9 ? 20 : bt));
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
        tick(4);
    endtask

    typedef struct {
        int bt;
        int d2;
        int ref_edge;
        bit is_err;
        int dvsr;
        bit locked;
        int lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // bt, d2, ref edge, error?, dvsr after, locked after, latency from ref edge
        tbl[0] = '{868,  1532, 3, 1'b1, 53,  1'b0, 1};          // 3rd interval 2400 > 2170
        tbl[1] = '{16,   16,   5, 1'b1, 53,  1'b0, 2};          // C=128, n=1
        tbl[2] = '{300,  300,  5, 1'b0, 18,  1'b1, 2};          // C=2400, n=19
        tbl[3] = '{1000, 1000, 5, 1'b0, 62,  1'b1, 2};          // C=8000, n=63
        tbl[4] = '{24,   24,   5, 1'b0, 1,   1'b1, 2};          // C=192, n=2 (minimum)
        tbl[5] = '{2032, 2032, 5, 1'b0, 126, 1'b1, 2};          // C=16256, n=127
        tbl[6] = '{868,  868,  5, 1'b0, 53,  1'b1, 2};          // C=6944, n=54
        tbl[7] = '{2100, 2100, 1, 1'b1, 53,  1'b1, C_MAX + 2};  // C saturates

        reset = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick(3);
        check("reset_dvsr",   int'(dvsr),       53);
        check("reset_valid",  int'(dvsr_valid), 0);
        check("reset_locked", int'(locked),     0);
        check("reset_busy",   int'(busy),       0);
        check("reset_error",  int'(error),      0);
        reset = 1'b0;
        tick(2);

        for (int v = 0; v < 8; v++) begin
            pulse_start();
            check("start_busy", int'(busy), 1);
            tick(30);
            send_frame(tbl[v].bt, tbl[v].d2, tbl[v].ref_edge, tbl[v].is_err,
                       tbl[v].dvsr, tbl[v].locked, tbl[v].lat);
            wait_drain(C_MAX + 100);
            check("final_busy",   int'(busy),   0);
            check("final_dvsr",   int'(dvsr),   tbl[v].dvsr);
            check("final_locked", int'(locked), int'(tbl[v].locked));
            $display("vector %0d: bt=%0d d2=%0d dvsr=%0d locked=%0d", v, tbl[v].bt,
                     tbl[v].d2, dvsr, locked);
        end

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", int'(busy), 0);
        tick(2);
        check("start_abort_idle_busy_later", int'(busy), 0);
        $display("seq start+abort in IDLE: busy=%0d", busy);

        // abort during MEASURE, coinciding with a falling edge
        pulse_start();
        tick(30);
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(30);
        check("measure_busy", int'(busy), 1);
        rx    = 1'b0;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy",  int'(busy),  0);
        check("abort_error", int'(error), 0);
        rx = 1'b1;
        tick(20);
        check("abort_dvsr",   int'(dvsr),   53);
        check("abort_locked", int'(locked), 1);
        $display("seq abort in MEASURE: busy=%0d dvsr=%0d locked=%0d", busy, dvsr, locked);

        // rx low at start: 15 high samples then a glitch must not arm the detector
        rx = 1'b0;
        pulse_start();
        tick(40);
        check("low_rx_busy", int'(busy), 1);
        rx = 1'b1;
        tick(15);
        rx = 1'b0;
        tick(24);
        rx = 1'b1;
        tick(100);
        send_frame(24, 24, 5, 1'b0, 1, 1'b1, 2);
        wait_drain(1000);
        check("idle_arm_dvsr", int'(dvsr), 1);
        $display("seq idle arming: dvsr=%0d locked=%0d", dvsr, locked);

        // asynchronous reset in the middle of a measurement
        pulse_start();
        tick(30);
        rx = 1'b0;
        tick(100);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_dvsr",   int'(dvsr),       53);
        check("async_reset_locked", int'(locked),     0);
        check("async_reset_busy",   int'(busy),       0);
        check("async_reset_valid",  int'(dvsr_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        tick(5);
        check("post_reset_busy", int'(busy), 0);
        $display("seq async reset: dvsr=%0d locked=%0d busy=%0d", dvsr, locked, busy);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
